// File: rtl/ad9833_wave_ctrl_if.sv
// Request and engine signals for ad9833_wave_ctrl.
// slave  : the controller's view (takes requests, drives the serial engine).
// master : the host/engine side's view.
interface ad9833_wave_ctrl_if;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [27:0] freq_word_i;
  logic [11:0] phase_word_i;
  logic [1:0]  wave_sel_i;
  logic        done_o;
  logic        err_o;
  logic        eng_start_o;
  logic [15:0] eng_data_o;
  logic        eng_busy_i;

  modport slave (
    input  cfg_valid_i, freq_word_i, phase_word_i, wave_sel_i, eng_busy_i,
    output cfg_ready_o, done_o, err_o, eng_start_o, eng_data_o
  );

  modport master (
    output cfg_valid_i, freq_word_i, phase_word_i, wave_sel_i, eng_busy_i,
    input  cfg_ready_o, done_o, err_o, eng_start_o, eng_data_o
  );
endinterface

// File: rtl/ad9833_wave_ctrl.sv
// AD9833 waveform controller: turns one {freq, phase, wave} request into the
// ordered 16-bit AD9833 word sequence and hands the words one at a time to the
// serial engine (start pulse + data, busy feedback). Always programs
// FREQ0/PHASE0 with FSELECT=PSELECT=0.
// Optional feature macro: AD9833_FAST_RETUNE_EN -- when defined, a request that
// only changes frequency after a completed sequence is sent as a 3-word
// glitch-free retune (no RESET).
module ad9833_wave_ctrl #(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic               sys_clk_i,
  input logic               rst_n_i,
  ad9833_wave_ctrl_if.slave bus
);

  localparam int unsigned TMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACK,
    S_BUSY,
    S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [27:0] freq_q;
  logic [11:0] phase_q;
  logic [1:0]  wave_q;
  logic        fast_q;
  logic        fast_now;
  logic        accept;
  logic        load_data;
  logic [15:0] data_nxt;
  logic [15:0] data_q;
  logic        start;
  logic        done;
  logic        err;

  function automatic logic [15:0] wave_bits(input logic [1:0] w);
    logic [15:0] b;
    case (w)
      2'd0:    b = 16'h0000;
      2'd1:    b = 16'h0002;
      2'd2:    b = 16'h0028;
      default: b = 16'h0020;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] word_of(input logic [2:0]  i,
                                          input logic [27:0] f,
                                          input logic [11:0] p,
                                          input logic [1:0]  w,
                                          input logic        fast);
    logic [15:0] d;
    d = '0;
    if (fast) begin
      case (i)
        3'd0:    d = 16'h2000 | wave_bits(w);
        3'd1:    d = {2'b01, f[13:0]};
        3'd2:    d = {2'b01, f[27:14]};
        default: d = '0;
      endcase
    end else begin
      case (i)
        3'd0:    d = 16'h2100;
        3'd1:    d = {2'b01, f[13:0]};
        3'd2:    d = {2'b01, f[27:14]};
        3'd3:    d = {4'hC, p};
        3'd4:    d = 16'h2000 | wave_bits(w);
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  assign accept = bus.cfg_valid_i && (state == S_IDLE);

`ifdef AD9833_FAST_RETUNE_EN
  logic programmed;

  // phase_q/wave_q double as the "last request" values for the retune decision
  assign fast_now = programmed && (bus.phase_word_i == phase_q) && (bus.wave_sel_i == wave_q);

  // Programmed flag: set by a completed sequence, cleared by abort or reset
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      programmed <= 1'b0;
    end else if (done) begin
      programmed <= 1'b1;
    end else if (err) begin
      programmed <= 1'b0;
    end
  end
`else
  assign fast_now = 1'b0;
`endif

  // State, counters, request and engine-data registers
  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      idx     <= '0;
      timer   <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      wave_q  <= '0;
      fast_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
      if (accept) begin
        freq_q  <= bus.freq_word_i;
        phase_q <= bus.phase_word_i;
        wave_q  <= bus.wave_sel_i;
        fast_q  <= fast_now;
      end
      if (load_data) begin
        data_q <= data_nxt;
      end
    end
  end

  // Next-state and pulse outputs; the engine word is registered on entry to
  // S_LOAD (taken straight from the inputs on accept) so it is valid together
  // with the start pulse and held until the next word is loaded.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    load_data = 1'b0;
    data_nxt  = '0;
    start     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cfg_valid_i) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
          load_data = 1'b1;
          data_nxt  = word_of(3'd0, bus.freq_word_i, bus.phase_word_i,
                              bus.wave_sel_i, fast_now);
        end
      end
      S_LOAD: begin
        start     = 1'b1;
        timer_nxt = '0;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        if (bus.eng_busy_i) begin
          state_nxt = S_BUSY;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_BUSY: begin
        timer_nxt = '0;
        if (!bus.eng_busy_i) begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (timer == TW'(GAP_CYCLES - 1)) begin
          if (idx == (fast_q ? 3'd2 : 3'd4)) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = idx + 3'd1;
            load_data = 1'b1;
            data_nxt  = word_of(idx + 3'd1, freq_q, phase_q, wave_q, fast_q);
            state_nxt = S_LOAD;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cfg_ready_o = (state == S_IDLE);
  assign bus.eng_start_o = start;
  assign bus.eng_data_o  = data_q;
  assign bus.done_o      = done;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_ad9833_wave_ctrl.sv
// Self-checking bench for ad9833_wave_ctrl with a behavioural engine model
// and a word-list reference model of the AD9833 programming sequence.
module tb_ad9833_wave_ctrl;
  localparam int unsigned GAP      = 4;
  localparam int unsigned ACK      = 16;
  localparam int          BUSY_LEN = 68;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  ad9833_wave_ctrl_if bus();

  ad9833_wave_ctrl #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .sys_clk_i (sys_clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Engine model: busy rises the cycle after a start pulse, falls 68 cycles later
  bit   eng_en   = 1'b1;
  int   eng_cnt  = 0;
  logic eng_busy = 1'b0;
  assign bus.eng_busy_i = eng_busy;

  always @(posedge sys_clk) begin
    if (!rst_n) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (bus.eng_start_o === 1'b1 && eng_en) begin
      eng_busy <= 1'b1;
      eng_cnt  <= BUSY_LEN;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_busy <= 1'b0;
    end
  end

  // Monitor: log issued words, busy falls and done/err pulses
  logic [15:0] words[$];
  int          start_cyc[$];
  int          fall_cyc[$];
  int          done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  logic        prev_busy = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.eng_start_o === 1'b1) begin
      words.push_back(bus.eng_data_o);
      start_cyc.push_back(cyc);
    end
    if (prev_busy && !bus.eng_busy_i) fall_cyc.push_back(cyc);
    prev_busy = bus.eng_busy_i;
    if (bus.done_o === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.err_o === 1'b1)  begin err_cnt++;  err_cyc  = cyc; end
  end

  // Reference model of the programming sequence
  bit          mprog   = 1'b0;
  logic [11:0] mlast_p = '0;
  logic [1:0]  mlast_w = '0;
  logic [15:0] exp_q[$];
  logic [15:0] wave_tab [4] = '{16'h0000, 16'h0002, 16'h0028, 16'h0020};

  task automatic build_exp(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    bit fast;
    int fi;
    fi = int'(f);
    exp_q.delete();
`ifdef AD9833_FAST_RETUNE_EN
    fast = mprog && (p == mlast_p) && (w == mlast_w);
`else
    fast = 1'b0;
`endif
    if (fast) begin
      exp_q.push_back(16'h2000 + wave_tab[w]);
      exp_q.push_back(16'h4000 + 16'(fi % 16384));
      exp_q.push_back(16'h4000 + 16'(fi / 16384));
    end else begin
      exp_q.push_back(16'h2100);
      exp_q.push_back(16'h4000 + 16'(fi % 16384));
      exp_q.push_back(16'h4000 + 16'(fi / 16384));
      exp_q.push_back(16'hC000 + 16'(p));
      exp_q.push_back(16'h2000 + wave_tab[w]);
    end
  endtask

  task automatic model_commit(input logic [11:0] p, input logic [1:0] w);
    mprog   = 1'b1;
    mlast_p = p;
    mlast_w = w;
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic clear_logs();
    words.delete();
    start_cyc.delete();
    fall_cyc.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic send_req(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w,
                          output bit ok);
    ok = 1'b0;
    bus.freq_word_i  = f;
    bus.phase_word_i = p;
    bus.wave_sel_i   = w;
    bus.cfg_valid_i  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.cfg_ready_o === 1'b1) begin
        @(posedge sys_clk);
        tick();
        bus.cfg_valid_i = 1'b0;
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt + err_cnt > 0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic run_seq(input string name, input logic [27:0] f, input logic [11:0] p,
                         input logic [1:0] w);
    bit ok;
    build_exp(f, p, w);
    clear_logs();
    send_req(f, p, w, ok);
    if (ok) wait_end(3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_complete: no done/err within bound, got 0 required 1", name);
    end
    checks++;
    if (words.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: words=%0d required %0d", name, words.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= words.size() || words[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_word%0d: got %h required %h", name, i,
                 (i < words.size()) ? words[i] : 16'hxxxx, exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      failures++;
      $display("FAIL %s_pulses: done=%0d err=%0d required done=1 err=0", name, done_cnt, err_cnt);
    end
    checks++;
    if (fall_cyc.size() == 0 || done_cyc - fall_cyc[fall_cyc.size()-1] != int'(GAP)) begin
      failures++;
      $display("FAIL %s_done_timing: delay=%0d required %0d", name,
               (fall_cyc.size() == 0) ? -1 : done_cyc - fall_cyc[fall_cyc.size()-1], GAP);
    end
    tick();
    checks++;
    if (bus.cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_after: got %b required 1", name, bus.cfg_ready_o);
    end
    model_commit(p, w);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cfg_valid_i  = 1'b0;
    bus.freq_word_i  = '0;
    bus.phase_word_i = '0;
    bus.wave_sel_i   = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    mprog = 1'b0;
    tick();
    checks++; if (bus.cfg_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", bus.cfg_ready_o); end
    checks++; if (bus.eng_start_o !== 1'b0) begin failures++; $display("FAIL reset_start: got %b required 0", bus.eng_start_o); end
    checks++; if (bus.eng_data_o !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h required 0000", bus.eng_data_o); end
    checks++; if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_pulses: done=%b err=%b required 0 0", bus.done_o, bus.err_o); end
  endtask

  task automatic test_full();
    run_seq("t1_full", 28'h0007DD4, 12'h000, 2'd0);
  endtask

  task automatic test_wave_phase();
    run_seq("t2_wave_phase", 28'h0123456, 12'h400, 2'd2);
    for (int i = 1; i < start_cyc.size(); i++) begin
      checks++;
      if (i > fall_cyc.size() || start_cyc[i] - fall_cyc[i-1] <= int'(GAP)) begin
        failures++;
        $display("FAIL t2_gap%0d: start %0d cycles after busy fall, required more than %0d", i,
                 (i > fall_cyc.size()) ? -1 : start_cyc[i] - fall_cyc[i-1], GAP);
      end
    end
  endtask

  task automatic test_fast();
    run_seq("t5_first", 28'h0007DD4, 12'h000, 2'd0);
    run_seq("t5_retune", 28'h0008000, 12'h000, 2'd0);
  endtask

  task automatic test_timeout();
    bit ok;
    build_exp(28'h0ABCDEF, mlast_p, mlast_w);
    eng_en = 1'b0;
    clear_logs();
    send_req(28'h0ABCDEF, mlast_p, mlast_w, ok);
    if (ok) wait_end(100, ok);
    checks++; if (err_cnt != 1 || done_cnt != 0) begin failures++; $display("FAIL t3_err: err=%0d done=%0d required err=1 done=0", err_cnt, done_cnt); end
    checks++; if (words.size() != 1) begin failures++; $display("FAIL t3_starts: got %0d required 1", words.size()); end
    checks++; if (words.size() == 0 || words[0] !== exp_q[0]) begin failures++; $display("FAIL t3_word0: got %h required %h", (words.size() == 0) ? 16'hxxxx : words[0], exp_q[0]); end
    checks++; if (start_cyc.size() == 0 || err_cyc - start_cyc[0] != int'(ACK)) begin failures++; $display("FAIL t3_err_timing: delay=%0d required %0d", (start_cyc.size() == 0) ? -1 : err_cyc - start_cyc[0], ACK); end
    tick();
    checks++; if (bus.cfg_ready_o !== 1'b1) begin failures++; $display("FAIL t3_ready: got %b required 1", bus.cfg_ready_o); end
    mprog  = 1'b0;
    eng_en = 1'b1;
    run_seq("t3_after", 28'h0ABCDEF, mlast_p, mlast_w);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    send_req(28'h0FEDCBA, 12'h321, 2'd1, ok);
    for (int i = 0; i < 1000 && words.size() < 3; i++) tick();
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (bus.eng_start_o !== 1'b0) begin failures++; $display("FAIL t4_start: got %b required 0", bus.eng_start_o); end
    checks++; if (bus.eng_data_o !== 16'h0000) begin failures++; $display("FAIL t4_data: got %h required 0000", bus.eng_data_o); end
    checks++; if (bus.cfg_ready_o !== 1'b1) begin failures++; $display("FAIL t4_ready: got %b required 1", bus.cfg_ready_o); end
    rst_n = 1'b1;
    mprog = 1'b0;
    repeat (200) tick();
    checks++; if (done_cnt != 0 || err_cnt != 0) begin failures++; $display("FAIL t4_pulses: done=%0d err=%0d required 0 0", done_cnt, err_cnt); end
    checks++; if (words.size() != 3) begin failures++; $display("FAIL t4_words: got %0d required 3", words.size()); end
  endtask

  task automatic test_stall();
    bit ok;
    int early;
    logic [27:0] fa, fb;
    logic [11:0] pa, pb;
    logic [1:0]  wa, wb;
    fa = 28'($urandom); pa = 12'($urandom); wa = 2'($urandom);
    fb = fa ^ 28'h5A5A5A5; pb = pa ^ 12'hFFF; wb = wa + 2'd1;
    build_exp(fa, pa, wa);
    clear_logs();
    bus.freq_word_i  = fa;
    bus.phase_word_i = pa;
    bus.wave_sel_i   = wa;
    bus.cfg_valid_i  = 1'b1;
    @(posedge sys_clk);
    tick();
    bus.freq_word_i  = fb;
    bus.phase_word_i = pb;
    bus.wave_sel_i   = wb;
    early = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt + err_cnt > 0) begin ok = 1'b1; break; end
      if (bus.cfg_ready_o === 1'b1) early++;
      tick();
    end
    checks++; if (!ok || early != 0) begin failures++; $display("FAIL t6_stall: ready cycles during sequence=%0d complete=%0b required 0 1", early, ok); end
    checks++; if (words.size() != exp_q.size()) begin failures++; $display("FAIL t6_count: got %0d required %0d", words.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= words.size() || words[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t6_word%0d: got %h required %h", i, (i < words.size()) ? words[i] : 16'hxxxx, exp_q[i]);
      end
    end
    model_commit(pa, wa);
    // held request B is accepted once the controller is idle again
    bus.cfg_valid_i = 1'b0;
    run_seq("t6_held", fb, pb, wb);
  endtask

  task automatic test_random();
    logic [27:0] f;
    logic [11:0] p;
    logic [1:0]  w;
    for (int n = 0; n < 6; n++) begin
      f = 28'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        p = mlast_p; w = mlast_w;
      end else begin
        p = 12'($urandom); w = 2'($urandom);
      end
      run_seq($sformatf("rand%0d", n), f, p, w);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_wave_phase();
    test_fast();
    test_timeout();
    test_reset_mid();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
